// File: rtl/ntt_sched.sv
// ntt_sched: stage/butterfly scheduler for a two-BFU NTT/INTT datapath.
//
// Walks all LOGN stages of an N-point forward (Cooley-Tukey) or inverse
// (Gentleman-Sande) transform. Each issue cycle emits two butterflies
// (four coefficient read addresses and two twiddle addresses). The same
// coefficient addresses are replayed as write-back addresses D = BFU_LAT+1
// cycles later. Each stage is followed by a D-cycle drain, so a stage never
// reads a coefficient before the previous stage has written it back.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             freeze request (only with NTT_SCHED_STALL_EN defined)
//   start, op         run request (sampled in idle), 0 = NTT / 1 = INTT
//   busy, done        run in progress, one-cycle completion pulse
//   stage             current stage index
//   rd_en, rd_*       read strobe and a/b addresses for BFU0/BFU1
//   tw_addr0/1        twiddle ROM addresses for BFU0/BFU1
//   wr_en, wr_*       write-back strobe and a/b addresses
//
// Optional feature macro: NTT_SCHED_STALL_EN adds the stall input.
module ntt_sched #(
  parameter int unsigned LOGN    = 9,
  parameter int unsigned BFU_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
`ifdef NTT_SCHED_STALL_EN
  input  logic            stall,
`endif
  input  logic            start,
  input  logic            op,
  output logic            busy,
  output logic            done,
  output logic [3:0]      stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_a0,
  output logic [LOGN-1:0] rd_b0,
  output logic [LOGN-1:0] rd_a1,
  output logic [LOGN-1:0] rd_b1,
  output logic [LOGN-1:0] tw_addr0,
  output logic [LOGN-1:0] tw_addr1,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_a0,
  output logic [LOGN-1:0] wr_b0,
  output logic [LOGN-1:0] wr_a1,
  output logic [LOGN-1:0] wr_b1
);

  localparam int unsigned D  = BFU_LAT + 1;
  localparam int unsigned DW = $clog2(D + 1);
  localparam int unsigned CW = LOGN - 2;
  localparam int unsigned EW = 4 * LOGN + 1;  // {valid, a0, b0, a1, b1}
  localparam logic [DW-1:0] DLast = DW'(D - 1);
  localparam logic [3:0]    SLast = 4'(LOGN - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e          st_q, st_d;
  logic [3:0]      s_q, s_d;
  logic [CW-1:0]   c_q, c_d;
  logic [DW-1:0]   dc_q, dc_d;
  logic            op_q, op_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_en_q, rd_en_d;
  logic [LOGN-1:0] ra0_q, ra0_d, rb0_q, rb0_d, ra1_q, ra1_d, rb1_q, rb1_d;
  logic [LOGN-1:0] tw0_q, tw0_d, tw1_q, tw1_d;
  logic [EW-1:0]   dl_q [D];
  logic [EW-1:0]   dl_d [D];
  logic [3*LOGN-1:0] bf0, bf1;
  logic            stall_w;

`ifdef NTT_SCHED_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // Returns {a, b, tw} for butterfly j of stage s. The half-span is a power of
  // two, so divide/modulo reduce to shift/mask. hs = log2(h); the twiddle base
  // N>>(s+1) or 1<<s is always 1 << (LOGN-1-hs).
  function automatic logic [3*LOGN-1:0] bfly(input logic [LOGN-1:0] j,
                                             input logic [3:0]      s,
                                             input logic            inv);
    logic [LOGN-1:0] one, h, g, o, a, b, tw;
    int unsigned     hs;
    one = LOGN'(1);
    hs  = inv ? {28'd0, s} : (LOGN - 1 - {28'd0, s});
    h   = one << hs;
    g   = j >> hs;
    o   = j & (h - one);
    a   = (g << (hs + 1)) | o;
    b   = a + h;
    tw  = (one << (LOGN - 1 - hs)) + g;
    return {a, b, tw};
  endfunction

  always_comb begin
    st_d    = st_q;
    s_d     = s_q;
    c_d     = c_q;
    dc_d    = dc_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = done_q;
    rd_en_d = rd_en_q;
    ra0_d   = ra0_q;
    rb0_d   = rb0_q;
    ra1_d   = ra1_q;
    rb1_d   = rb1_q;
    tw0_d   = tw0_q;
    tw1_d   = tw1_q;
    bf0     = '0;
    bf1     = '0;
    for (int k = 0; k < D; k++) dl_d[k] = dl_q[k];

    // A stalled cycle leaves every register untouched, so the schedule simply
    // resumes where it was once the stall clears.
    if (!stall_w) begin
      unique case (st_q)
        StIdle: begin
          if (start) begin
            st_d = StIssue;
            s_d  = '0;
            c_d  = '0;
            op_d = op;
          end
        end
        StIssue: begin
          if (&c_q) begin
            st_d = StDrain;
            c_d  = '0;
            dc_d = '0;
          end else begin
            c_d = c_q + CW'(1);
          end
        end
        StDrain: begin
          if (dc_q == DLast) begin
            if (s_q == SLast) begin
              st_d = StDone;
            end else begin
              st_d = StIssue;
              s_d  = s_q + 4'd1;
            end
          end else begin
            dc_d = dc_q + DW'(1);
          end
        end
        StDone: st_d = StIdle;
        default: st_d = StIdle;
      endcase

      // Outputs are registered from the next state so they line up with it.
      busy_d  = (st_d == StIssue) || (st_d == StDrain);
      done_d  = (st_d == StDone);
      rd_en_d = (st_d == StIssue);
      if (st_d == StIssue) begin
        bf0   = bfly({1'b0, c_d, 1'b0}, s_d, op_d);
        bf1   = bfly({1'b0, c_d, 1'b1}, s_d, op_d);
        ra0_d = bf0[3*LOGN-1 -: LOGN];
        rb0_d = bf0[2*LOGN-1 -: LOGN];
        tw0_d = bf0[LOGN-1:0];
        ra1_d = bf1[3*LOGN-1 -: LOGN];
        rb1_d = bf1[2*LOGN-1 -: LOGN];
        tw1_d = bf1[LOGN-1:0];
      end

      // The currently visible issue enters the delay line; it reaches the tail
      // D cycles after it was shown on the read port.
      dl_d[0] = {rd_en_q, ra0_q, rb0_q, ra1_q, rb1_q};
      for (int k = 1; k < D; k++) dl_d[k] = dl_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StIdle;
      s_q     <= '0;
      c_q     <= '0;
      dc_q    <= '0;
      op_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      ra0_q   <= '0;
      rb0_q   <= '0;
      ra1_q   <= '0;
      rb1_q   <= '0;
      tw0_q   <= '0;
      tw1_q   <= '0;
      for (int k = 0; k < D; k++) dl_q[k] <= '0;
    end else begin
      st_q    <= st_d;
      s_q     <= s_d;
      c_q     <= c_d;
      dc_q    <= dc_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      ra0_q   <= ra0_d;
      rb0_q   <= rb0_d;
      ra1_q   <= ra1_d;
      rb1_q   <= rb1_d;
      tw0_q   <= tw0_d;
      tw1_q   <= tw1_d;
      for (int k = 0; k < D; k++) dl_q[k] <= dl_d[k];
    end
  end

  // Strobes are masked in the stalled cycle itself; the frozen entry is
  // presented again once the stall clears.
  assign busy     = busy_q;
  assign done     = done_q & ~stall_w;
  assign stage    = s_q;
  assign rd_en    = rd_en_q & ~stall_w;
  assign rd_a0    = ra0_q;
  assign rd_b0    = rb0_q;
  assign rd_a1    = ra1_q;
  assign rd_b1    = rb1_q;
  assign tw_addr0 = tw0_q;
  assign tw_addr1 = tw1_q;
  assign wr_en    = dl_q[D-1][EW-1] & ~stall_w;
  assign wr_a0    = dl_q[D-1][4*LOGN-1 -: LOGN];
  assign wr_b0    = dl_q[D-1][3*LOGN-1 -: LOGN];
  assign wr_a1    = dl_q[D-1][2*LOGN-1 -: LOGN];
  assign wr_b1    = dl_q[D-1][LOGN-1:0];

endmodule

// File: tb/tb_ntt_sched.sv
// tb_ntt_sched: self-checking bench for ntt_sched at LOGN=3, BFU_LAT=4.
// A schedule model built from the transform's index arithmetic gives the
// expected outputs per logical cycle; stalled cycles do not advance logical
// time. One negedge process compares the DUT against it every cycle of a run.
module tb_ntt_sched;
  localparam int LOGN = 3;
  localparam int N    = 8;
  localparam int D    = 5;
  localparam int SPS  = N / 4 + D;  // cycles per stage
  localparam int T    = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, op_in, stall_v;
  logic       busy, done, rd_en, wr_en;
  logic [3:0] stage;
  logic [2:0] rd_a0, rd_b0, rd_a1, rd_b1, tw_addr0, tw_addr1;
  logic [2:0] wr_a0, wr_b0, wr_a1, wr_b1;

  ntt_sched #(.LOGN(3), .BFU_LAT(4)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef NTT_SCHED_STALL_EN
    .stall    (stall_v),
`endif
    .start    (start),
    .op       (op_in),
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .rd_en    (rd_en),
    .rd_a0    (rd_a0),
    .rd_b0    (rd_b0),
    .rd_a1    (rd_a1),
    .rd_b1    (rd_b1),
    .tw_addr0 (tw_addr0),
    .tw_addr1 (tw_addr1),
    .wr_en    (wr_en),
    .wr_a0    (wr_a0),
    .wr_b0    (wr_b0),
    .wr_a1    (wr_a1),
    .wr_b1    (wr_b1)
  );

  int checks = 0;
  int errors = 0;
  int exp_rd[T], exp_wr[T], exp_busy[T], exp_done[T], exp_stage[T];
  int exp_ra0[T], exp_rb0[T], exp_ra1[T], exp_rb1[T], exp_tw0[T], exp_tw1[T];
  int exp_wa0[T], exp_wb0[T], exp_wa1[T], exp_wb1[T];
  int cyc = 0;
  int lcyc = 0;
  bit chk_on = 1'b0;
  int done_cyc, first_rd;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Schedule model: for every stage s and issue slot c, butterflies j=2c,2c+1
  // with g = j/h, o = j%h, a = 2hg+o, b = a+h, issued at 1 + s*SPS + c and
  // written back D cycles later. A reset at rst_at wipes everything after it.
  task automatic build(input bit inv, input int rst_at);
    for (int t = 0; t < T; t++) begin
      exp_rd[t] = 0; exp_wr[t] = 0; exp_busy[t] = 0; exp_done[t] = 0; exp_stage[t] = 0;
      exp_ra0[t] = 0; exp_rb0[t] = 0; exp_ra1[t] = 0; exp_rb1[t] = 0;
      exp_tw0[t] = 0; exp_tw1[t] = 0;
      exp_wa0[t] = 0; exp_wb0[t] = 0; exp_wa1[t] = 0; exp_wb1[t] = 0;
    end
    for (int s = 0; s < LOGN; s++) begin
      for (int c = 0; c < N / 4; c++) begin
        int t, h;
        t = 1 + s * SPS + c;
        h = inv ? (1 << s) : (N >> (s + 1));
        for (int k = 0; k < 2; k++) begin
          int j, g, o, a, b, tw;
          j  = 2 * c + k;
          g  = j / h;
          o  = j % h;
          a  = g * 2 * h + o;
          b  = a + h;
          tw = inv ? ((N >> (s + 1)) + g) : ((1 << s) + g);
          if (k == 0) begin
            exp_ra0[t] = a; exp_rb0[t] = b; exp_tw0[t] = tw;
            exp_wa0[t+D] = a; exp_wb0[t+D] = b;
          end else begin
            exp_ra1[t] = a; exp_rb1[t] = b; exp_tw1[t] = tw;
            exp_wa1[t+D] = a; exp_wb1[t+D] = b;
          end
        end
        exp_rd[t]   = 1;
        exp_wr[t+D] = 1;
      end
    end
    for (int t = 1; t < 1 + LOGN * SPS; t++) begin
      exp_busy[t]  = 1;
      exp_stage[t] = (t - 1) / SPS;
    end
    exp_done[1 + LOGN * SPS] = 1;
    if (rst_at >= 0) begin
      for (int t = rst_at + 1; t < T; t++) begin
        exp_rd[t] = 0; exp_wr[t] = 0; exp_busy[t] = 0; exp_done[t] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      int t;
      t = lcyc;
      if (stall_v) begin
        chk("stall_rd_en", int'(rd_en), 0);
        chk("stall_wr_en", int'(wr_en), 0);
        chk("stall_done", int'(done), 0);
        chk("stall_busy", int'(busy), exp_busy[t]);
      end else begin
        chk("rd_en", int'(rd_en), exp_rd[t]);
        chk("wr_en", int'(wr_en), exp_wr[t]);
        chk("busy", int'(busy), exp_busy[t]);
        chk("done", int'(done), exp_done[t]);
        if (exp_busy[t] != 0) chk("stage", int'(stage), exp_stage[t]);
        if (exp_rd[t] != 0) begin
          chk("rd_a0", int'(rd_a0), exp_ra0[t]);
          chk("rd_b0", int'(rd_b0), exp_rb0[t]);
          chk("rd_a1", int'(rd_a1), exp_ra1[t]);
          chk("rd_b1", int'(rd_b1), exp_rb1[t]);
          chk("tw_addr0", int'(tw_addr0), exp_tw0[t]);
          chk("tw_addr1", int'(tw_addr1), exp_tw1[t]);
        end
        if (exp_wr[t] != 0) begin
          chk("wr_a0", int'(wr_a0), exp_wa0[t]);
          chk("wr_b0", int'(wr_b0), exp_wb0[t]);
          chk("wr_a1", int'(wr_a1), exp_wa1[t]);
          chk("wr_b1", int'(wr_b1), exp_wb1[t]);
        end
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (rd_en && first_rd < 0) first_rd = cyc;
    end
  end

  // One run: start in cycle 0, optional extra start, reset and stall window.
  task automatic run(input bit inv, input int ncyc, input int start2, input int rst_at,
                     input int st_lo, input int st_hi);
    build(inv, rst_at);
    done_cyc = -1;
    first_rd = -1;
    lcyc     = 0;
    for (int r = 0; r < ncyc; r++) begin
      cyc     = r;
      start   = (r == 0) || (r == start2);
      op_in   = (r == 0) ? inv : ~inv;
      rst     = (r == rst_at);
      stall_v = (r >= st_lo) && (r <= st_hi);
      chk_on  = 1'b1;
      @(posedge clk);
      #1;
      if (!stall_v) lcyc++;
    end
    chk_on  = 1'b0;
    start   = 1'b0;
    rst     = 1'b0;
    stall_v = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b1;
    op_in   = 1'b0;
    stall_v = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_stage", int'(stage), 0);
      chk("rst_rd_a0", int'(rd_a0), 0);
      chk("rst_tw_addr1", int'(tw_addr1), 0);
      chk("rst_wr_b1", int'(wr_b1), 0);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;

    // NTT, with an ignored start (and op flip) in cycle 5.
    run(1'b0, 23, 5, -1, -1, -2);
    chk("ntt_done_cycle", done_cyc, 22);
    chk("ntt_first_rd", first_rd, 1);
    chk("model_ntt_tw0_c9", exp_tw0[9], 3);
    chk("model_ntt_a0_c9", exp_ra0[9], 4);
    chk("model_ntt_b0_c9", exp_rb0[9], 6);
    chk("model_ntt_tw1_c16", exp_tw1[16], 7);
    chk("model_ntt_wa0_c14", exp_wa0[14], 4);

    // INTT started right after IDLE is reached; start in the DONE cycle ignored.
    run(1'b1, 32, 22, -1, -1, -2);
    chk("intt_done_cycle", done_cyc, 22);
    chk("intt_first_rd", first_rd, 1);
    chk("model_intt_a1_c1", exp_ra1[1], 2);
    chk("model_intt_tw1_c1", exp_tw1[1], 5);
    chk("model_intt_tw0_c15", exp_tw0[15], 1);

    // Reset in cycle 10 of an NTT run: nothing emerges afterwards.
    run(1'b0, 22, -1, 10, -1, -2);
    chk("rst_mid_no_done", done_cyc, -1);

`ifdef NTT_SCHED_STALL_EN
    run(1'b0, 30, -1, -1, 3, 6);
    chk("stall_done_cycle", done_cyc, 26);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
